// File: rtl/muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply, restoring divide, one operation in flight.
module muldiv #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] s_data,
    input  logic [WORD_SIZE-1:0] t_data,
    input  logic                 hi_we,
    input  logic                 lo_we,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;            // |s|: multiplicand / dividend magnitude
    logic [W-1:0]    b_q, b_d;            // |t|: multiplier / divisor magnitude
    logic [W-1:0]    acc_hi_q, acc_hi_d;  // partial product high half / remainder
    logic [W-1:0]    acc_lo_q, acc_lo_d;  // multiplier bits / quotient bits
    logic            is_div_q, is_div_d;
    logic            prod_neg_q, prod_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div_zero_q, div_zero_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            in_signed;
    logic            s_neg, t_neg;
    logic [W-1:0]    s_mag, t_mag;
    logic [W:0]      mul_sum;
    logic [W:0]      rem_shift;
    logic [W:0]      rem_sub;
    logic            rem_ge;
    logic [2*W-1:0]  prod_raw;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        in_signed = ~op[0];
        s_neg     = in_signed & s_data[W-1];
        t_neg     = in_signed & t_data[W-1];
        s_mag     = s_neg ? -s_data : s_data;
        t_mag     = t_neg ? -t_data : t_data;

        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        rem_shift = {acc_hi_q, acc_lo_q[W-1]};
        rem_ge    = rem_shift >= {1'b0, b_q};
        rem_sub   = rem_shift - {1'b0, b_q};
        prod_raw  = {acc_hi_q, acc_lo_q};

        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        is_div_d   = is_div_q;
        prod_neg_d = prod_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Register writes arriving with start are dropped on purpose.
                    a_d        = s_mag;
                    b_d        = t_mag;
                    acc_hi_d   = '0;
                    acc_lo_d   = op[1] ? s_mag : t_mag;
                    is_div_d   = op[1];
                    prod_neg_d = s_neg ^ t_neg;
                    rem_neg_d  = s_neg;
                    div_zero_d = (t_data == '0);
                    cnt_d      = CW'(W);
                    state_d    = RUN;
                end else begin
                    if (hi_we) hi_d = s_data;
                    if (lo_we) lo_d = s_data;
                end
            end

            RUN: begin
                if (is_div_q) begin
                    acc_hi_d = rem_ge ? rem_sub[W-1:0] : rem_shift[W-1:0];
                    acc_lo_d = {acc_lo_q[W-2:0], rem_ge};
                end else begin
                    acc_hi_d = mul_sum[W:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end

            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_neg_q ? -prod_raw : prod_raw;
                end else if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = rem_neg_q ? -a_q : a_q;
                end else begin
                    lo_d = prod_neg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = rem_neg_q  ? -acc_hi_q : acc_hi_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            is_div_q   <= 1'b0;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            is_div_q   <= is_div_d;
            prod_neg_q <= prod_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
